insn_queue: RTL
===============

Name: insn_queue

Overview:
- Decoupling FIFO between fetch and dispatch.
- Buffers fetched instruction words so a dispatch stall does not back up fetch immediately, and presents one instruction per cycle to dispatch.
- Flushes all buffered instructions when the ROB signals a branch mispredict.
- Instantiated in core between `fetch` and `dispatch`. It replaces the direct `in_fetch_insnbits`/`in_fetch_done` path into dispatch.

Parameters:
- DEPTH, 8: number of entries; must be a power of two and at least 2.
- STALL_SLACK, 1: free entries held in reserve; `out_fetch_stall` asserts when count >= DEPTH-STALL_SLACK. Legal range 0..DEPTH-1.
- WIDTH, `INSNBITS_SIZE: instruction word width.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_fetch_done  input  1  fetch presents a valid instruction this cycle.
- in_fetch_insnbits  input  WIDTH  instruction word from fetch.
- out_fetch_stall  output  1  tells fetch to hold; derived from registered count only.
- out_d_done  output  1  head entry valid for dispatch.
- out_d_insnbits  output  WIDTH  head instruction word.
- in_d_stall  input  1  dispatch cannot accept this cycle (ROB/RS full).
- in_rob_is_mispred  input  1  flush request from ROB.
- out_count  output  $clog2(DEPTH)+1  current occupancy.
- out_overflow  output  1  sticky error: a push arrived while full with no pop.

Behaviour:
- Reset (in_rst=1 at edge): head=0, tail=0, count=0, out_overflow=0.
  - Storage contents are don't-care.
  - Outputs after reset: out_d_done=0, out_d_insnbits=0 (forced 0 when empty), out_fetch_stall=0 (or 1 if STALL_SLACK >= DEPTH), out_count=0.
  - Reset takes priority over every other input.
- Push = in_fetch_done & ~full | in_fetch_done & full & pop.
  - Writes mem[tail]; tail = tail+1 mod DEPTH.
- Pop = out_d_done & ~in_d_stall.
  - head = head+1 mod DEPTH.
- out_d_done = (count != 0). out_d_insnbits = mem[head] when count != 0, else 0.
  - These are combinational reads of registered state; there is no combinational path from any input.
- Latency: a word pushed at edge N is visible on out_d at edge N+1 when the queue was empty.
  - No empty bypass. A push and a pop in the same cycle on an empty queue cannot happen, because out_d_done=0.
- Count update: count += push - pop.
  - Push & pop together leave count unchanged; this is legal at full and at any level.
- Full (count==DEPTH) with in_fetch_done=1 and no pop: the word is dropped, state is unchanged, out_overflow is set to 1 and held until reset.
  - Fetch honouring out_fetch_stall must never cause this.
- Order is strictly FIFO; pointer wrap is a natural modulo-DEPTH rollover.
- Flush (in_rob_is_mispred=1 at edge, no reset):
  - head=tail=0, count=0.
  - Any same-cycle push and pop are discarded; flush has priority.
  - out_overflow is unchanged.
  - out_d_done=0 in the next cycle.
- out_fetch_stall = (count >= DEPTH-STALL_SLACK), computed from registered count.
- in_d_stall while out_d_done=1: the head word and out_d_done are held stable until accepted. This is the valid/stall handshake contract with dispatch.
- A word of all-zero insnbits is ordinary data; the queue does not interpret it.

Decomposition:
- Shared package (data_structures.sv):
  - `INSNBITS_SIZE (existing).
  - New `IQ_DEPTH and `IQ_STALL_SLACK defaults, used by core to set DEPTH and STALL_SLACK.
  - Occupancy width derived as `IQ_CNT_SIZE.
- Optional single sub-module iq_storage: DEPTH x WIDTH register array with one write port and one async read port.
  - Pointer, count and flush control stay in insn_queue.

Test Plan:
- Reset then 3 pushes (0xAAAA0001..0003) with in_d_stall=0 -> out_d_done rises 1 cycle after the first push; words exit in order 0001,0002,0003; out_count peaks at 1.
- Hold in_d_stall=1 and push 8 words, DEPTH=8, STALL_SLACK=1 -> out_fetch_stall=1 once out_count=7; out_count=8; out_d_insnbits stays at the first word.
- Full, in_fetch_done=1 with in_d_stall=0 in the same cycle -> push and pop together; out_count stays 8; out_overflow=0; order preserved across the pointer wrap.
- Full, in_d_stall=1, in_fetch_done=1 -> word dropped; out_overflow=1 sticky; out_count=8.
- Queue holding 5 entries, in_rob_is_mispred=1 together with a push and a pop -> next cycle out_count=0, out_d_done=0; the next pushed word 0x1234 appears alone at head.
- in_rst asserted with 4 entries and overflow set -> next cycle all outputs at reset values; out_overflow=0.

Source files
------------

// File: rtl/insn_queue_pkg.sv
// Shared sizing for the fetch-to-dispatch instruction queue.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package insn_queue_pkg;

    localparam int INSNBITS_SIZE  = 32;
    localparam int IQ_DEPTH       = 8;
    localparam int IQ_STALL_SLACK = 1;
    localparam int IQ_CNT_SIZE    = $clog2(IQ_DEPTH) + 1;

    typedef logic [INSNBITS_SIZE-1:0] insn_t;

endpackage : insn_queue_pkg

// File: rtl/insn_queue_storage.sv
// DEPTH x WIDTH register array: one write port, one asynchronous read port.
// Latency: a write lands at the clock edge; the read is combinational.
// Backpressure: none; the owner decides when to write.
module insn_queue_storage #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     in_clk,
    input  logic                     in_we,
    input  logic [$clog2(DEPTH)-1:0] in_waddr,
    input  logic [WIDTH-1:0]         in_wdata,
    input  logic [$clog2(DEPTH)-1:0] in_raddr,
    output logic [WIDTH-1:0]         out_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (in_we) begin
            mem_d[in_waddr] = in_wdata;
        end
    end

    // Storage is never reset; contents are meaningless until written.
    always_ff @(posedge in_clk) begin
        mem_q <= mem_d;
    end

    assign out_rdata = mem_q[in_raddr];

endmodule : insn_queue_storage

// File: rtl/insn_queue.sv
// Decoupling FIFO between fetch and dispatch, flushed on ROB mispredict.
// Latency: a word pushed into an empty queue is at the head one cycle later (no bypass).
// Backpressure: dispatch holds the head with in_d_stall; fetch is told to hold via out_fetch_stall.
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int DEPTH       = IQ_DEPTH,
    parameter int STALL_SLACK = IQ_STALL_SLACK,
    parameter int WIDTH       = INSNBITS_SIZE
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       in_fetch_done,
    input  logic [WIDTH-1:0]           in_fetch_insnbits,
    output logic                       out_fetch_stall,
    output logic                       out_d_done,
    output logic [WIDTH-1:0]           out_d_insnbits,
    input  logic                       in_d_stall,
    input  logic                       in_rob_is_mispred,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       out_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_SLACK);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             full;
    logic             not_empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic             wr_en;
    logic [WIDTH-1:0] head_word;

    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);
    assign pop       = not_empty & ~in_d_stall;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push      = in_fetch_done & (~full | pop);
    assign drop      = in_fetch_done & full & ~pop;
    // A flush discards the same-cycle push, so the write is suppressed too.
    assign wr_en     = push & ~in_rob_is_mispred;

    // Pointer, occupancy and sticky-overflow next state; flush wins over push/pop.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (in_rob_is_mispred) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state register; reset overrides everything.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    insn_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_storage (
        .in_clk    (in_clk),
        .in_we     (wr_en),
        .in_waddr  (tail_q),
        .in_wdata  (in_fetch_insnbits),
        .in_raddr  (head_q),
        .out_rdata (head_word)
    );

    // All outputs come from registered state only.
    assign out_d_done      = not_empty;
    assign out_d_insnbits  = not_empty ? head_word : '0;
    assign out_fetch_stall = (count_q >= STALL_CNT);
    assign out_count       = count_q;
    assign out_overflow    = overflow_q;

endmodule : insn_queue
